// File: rtl/cv32e40p_voter_fault_ctrl_if.sv
// rtl/cv32e40p_voter_fault_ctrl_if.sv - voter status / fault controller interface
interface cv32e40p_voter_fault_ctrl_if #(
    parameter int CNT_W = 8
);
    logic                  valid_i;
    logic [2:0]            block_err_i;
    logic                  err_detected_i;
    logic                  err_corrected_i;
    logic                  clear_i;
    logic [2:0]            broken_block_o;
    logic [1:0]            state_o;
    logic                  fatal_o;
    logic [2:0][CNT_W-1:0] err_cnt_o;

    modport master (
        output valid_i, block_err_i, err_detected_i, err_corrected_i, clear_i,
        input  broken_block_o, state_o, fatal_o, err_cnt_o
    );

    modport slave (
        input  valid_i, block_err_i, err_detected_i, err_corrected_i, clear_i,
        output broken_block_o, state_o, fatal_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_voter_fault_ctrl.sv
// rtl/cv32e40p_voter_fault_ctrl.sv - TMR voter error counting, replica retirement and fatal state
module cv32e40p_voter_fault_ctrl #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 8,
    parameter int DECAY  = 1024
) (
    input logic clk,
    input logic rst_n,
    cv32e40p_voter_fault_ctrl_if.slave bus
);
    localparam int DW = $clog2(DECAY);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_TMR  = 2'b00,
        ST_DMR  = 2'b01,
        ST_FAIL = 2'b10
    } state_t;

    state_t                state_q;
    logic                  fatal_q;
    logic [2:0]            broken_q;
    logic [2:0][CNT_W-1:0] cnt_q;
    logic [DW-1:0]         timer_q;

    logic [2:0] unmasked;
    logic [1:0] n_unmasked;
    logic [2:0] reach;
    logic [2:0] new_broken;
    logic [1:0] n_new_broken;
    logic [2:0] inc;
    logic       timer_wrap;
    logic       decay_fire;
    logic       go_fail;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    always_comb begin
        unmasked     = bus.block_err_i & ~broken_q;
        n_unmasked   = pop3(unmasked);
        for (int i = 0; i < 3; i++) begin
            reach[i] = !broken_q[i] && (cnt_q[i] >= CNT_W'(THRESH));
        end
        new_broken   = broken_q | reach;
        n_new_broken = pop3(new_broken);
        inc          = (bus.valid_i && n_unmasked == 2'd1) ? unmasked : 3'b000;
        timer_wrap   = (timer_q == DW'(DECAY - 1));
        // An error increment in the same cycle wins over a decay step.
        decay_fire   = bus.valid_i && !bus.err_detected_i && timer_wrap && (inc == 3'b000);
        go_fail      = (n_new_broken >= 2'd2);
        if (bus.valid_i) begin
            if (state_q == ST_TMR) begin
                go_fail = go_fail || (n_unmasked >= 2'd2) ||
                          (bus.err_detected_i && !bus.err_corrected_i);
            end else if (state_q == ST_DMR) begin
                go_fail = go_fail || bus.err_detected_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_TMR;
            fatal_q  <= 1'b0;
            broken_q <= 3'b000;
            cnt_q    <= '0;
            timer_q  <= '0;
        end else if (bus.clear_i) begin
            state_q  <= ST_TMR;
            fatal_q  <= 1'b0;
            broken_q <= 3'b000;
            cnt_q    <= '0;
            timer_q  <= '0;
        end else if (state_q != ST_FAIL) begin
            // The cycle that enters FAIL leaves counters, broken bits and timer untouched.
            if (go_fail) begin
                state_q <= ST_FAIL;
                fatal_q <= 1'b1;
            end else begin
                broken_q <= new_broken;
                if (reach != 3'b000) begin
                    state_q <= ST_DMR;
                end
                for (int i = 0; i < 3; i++) begin
                    if (inc[i]) begin
                        if (cnt_q[i] != CNT_MAX) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end else if (decay_fire && !broken_q[i] && cnt_q[i] != '0) begin
                        cnt_q[i] <= cnt_q[i] - 1'b1;
                    end
                end
                if (bus.valid_i) begin
                    if (bus.err_detected_i || timer_wrap) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.state_o        = state_q;
    assign bus.fatal_o        = fatal_q;
    assign bus.broken_block_o = broken_q;
    assign bus.err_cnt_o      = cnt_q;
endmodule
